// File: rtl/apb_pkg.sv
// Shared APB arbiter types, address-window defaults and legality helper.
// Consumed by apb_master_arbiter (optional macro APB_ARB_TIMEOUT_EN) and apb_arb_rr_select.
package apb_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} arb_state_t;

  localparam int          APB_ARB_NUM_REQ = 2;
  localparam logic [31:0] APB_START_ADDR  = 32'h8c00_0000;
  localparam logic [31:0] APB_END_ADDR    = 32'h8c00_07FF;
  localparam int unsigned APB_MAX_WAIT    = 0;

  // Unsigned window compare plus word alignment; no wrap at the top of the map.
  function automatic logic apb_addr_ok(input logic [31:0] a,
                                       input logic [31:0] lo,
                                       input logic [31:0] hi);
    return (a >= lo) && (a <= hi) && (a[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/apb_arb_rr_select.sv
// Combinational round-robin winner for the two APB requesters.
module apb_arb_rr_select
  import apb_pkg::*;
(
  input  logic [APB_ARB_NUM_REQ-1:0] req_i,
  input  logic                       last_grant_i,
  output logic                       valid_o,
  output logic                       grant_o
);

  // On a tie the requester not served last wins; otherwise the sole requester.
  always_comb begin
    valid_o = |req_i;
    grant_o = (&req_i) ? ~last_grant_i : req_i[1];
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Two-requester round-robin APB master with address/alignment checking.
// Define APB_ARB_TIMEOUT_EN to abort ACCESS after MAX_WAIT not-ready cycles.
module apb_master_arbiter
  import apb_pkg::*;
#(
  parameter logic [31:0] START_ADDR = APB_START_ADDR,
  parameter logic [31:0] END_ADDR   = APB_END_ADDR,
  parameter int unsigned MAX_WAIT   = APB_MAX_WAIT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_in,
  input  logic [1:0]  write_in,
  input  logic [31:0] addr0_in,
  input  logic [31:0] addr1_in,
  input  logic [31:0] wdata0_in,
  input  logic [31:0] wdata1_in,
  output logic [1:0]  ack_out,
  output logic [31:0] rdata_out,
  output logic        err_out,
  output logic        psel_out,
  output logic        penable_out,
  output logic        pwrite_out,
  output logic [31:0] paddr_out,
  output logic [31:0] pwdata_out,
  input  logic [31:0] prdata_in,
  input  logic        pready_in,
  input  logic        pslverr_in
);

  arb_state_t  state_q, state_d;
  logic        grant_q, grant_d;
  logic        last_grant_q, last_grant_d;
  logic [1:0]  ack_q, ack_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        psel_q, psel_d;
  logic        penable_q, penable_d;
  logic        pwrite_q, pwrite_d;
  logic [31:0] paddr_q, paddr_d;
  logic [31:0] pwdata_q, pwdata_d;

  logic        sel_valid, sel_grant;
  logic [31:0] sel_addr;

  apb_arb_rr_select u_rr (
    .req_i       (req_in),
    .last_grant_i(last_grant_q),
    .valid_o     (sel_valid),
    .grant_o     (sel_grant)
  );

  assign sel_addr = sel_grant ? addr1_in : addr0_in;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
`endif

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    ack_d        = 2'b00;
    rdata_d      = rdata_q;
    err_d        = err_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
`ifdef APB_ARB_TIMEOUT_EN
    wait_cnt_d   = wait_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (sel_valid) begin
          grant_d      = sel_grant;
          last_grant_d = sel_grant;
          pwrite_d     = write_in[sel_grant];
          paddr_d      = sel_addr;
          pwdata_d     = sel_grant ? wdata1_in : wdata0_in;
`ifdef APB_ARB_TIMEOUT_EN
          wait_cnt_d   = '0;
`endif
          if (apb_addr_ok(sel_addr, START_ADDR, END_ADDR)) begin
            state_d = SETUP;
            psel_d  = 1'b1;
          end else begin
            // Rejected without touching the bus; ack straight from DONE.
            state_d = DONE;
            ack_d   = sel_grant ? 2'b10 : 2'b01;
            err_d   = 1'b1;
            rdata_d = '0;
          end
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (pready_in) begin
          state_d   = DONE;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          ack_d     = grant_q ? 2'b10 : 2'b01;
          rdata_d   = pwrite_q ? 32'h0 : prdata_in;
          err_d     = pslverr_in;
        end
`ifdef APB_ARB_TIMEOUT_EN
        else if (wait_cnt_q == WAIT_W'(MAX_WAIT)) begin
          state_d   = DONE;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          ack_d     = grant_q ? 2'b10 : 2'b01;
          rdata_d   = '0;
          err_d     = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
        rdata_d = '0;
        err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      ack_q        <= 2'b00;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      ack_q        <= ack_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
    end
  end

`ifdef APB_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_cnt_q <= '0;
    else        wait_cnt_q <= wait_cnt_d;
  end
`endif

  assign ack_out     = ack_q;
  assign rdata_out   = rdata_q;
  assign err_out     = err_q;
  assign psel_out    = psel_q;
  assign penable_out = penable_q;
  assign pwrite_out  = pwrite_q;
  assign paddr_out   = paddr_q;
  assign pwdata_out  = pwdata_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter; inputs change and outputs are checked on negedge.
module tb_apb_master_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_in, write_in;
  logic [31:0] addr0_in, addr1_in, wdata0_in, wdata1_in;
  logic [1:0]  ack_out;
  logic [31:0] rdata_out;
  logic        err_out, psel_out, penable_out, pwrite_out;
  logic [31:0] paddr_out, pwdata_out, prdata_in;
  logic        pready_in, pslverr_in;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  apb_master_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_in(req_in), .write_in(write_in),
    .addr0_in(addr0_in), .addr1_in(addr1_in),
    .wdata0_in(wdata0_in), .wdata1_in(wdata1_in),
    .ack_out(ack_out), .rdata_out(rdata_out), .err_out(err_out),
    .psel_out(psel_out), .penable_out(penable_out), .pwrite_out(pwrite_out),
    .paddr_out(paddr_out), .pwdata_out(pwdata_out),
    .prdata_in(prdata_in), .pready_in(pready_in), .pslverr_in(pslverr_in)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; req_in = 2'b00; write_in = 2'b00;
    addr0_in = '0; addr1_in = '0; wdata0_in = '0; wdata1_in = '0;
    prdata_in = '0; pready_in = 1'b1; pslverr_in = 1'b0;
    #22;
    chk("rst_psel", {31'b0, psel_out}, 32'h0);
    chk("rst_pen",  {31'b0, penable_out}, 32'h0);
    chk("rst_ack",  {30'b0, ack_out}, 32'h0);
    chk("rst_err",  {31'b0, err_out}, 32'h0);
    chk("rst_rdata", rdata_out, 32'h0);
    chk("rst_paddr", paddr_out, 32'h0);
    step(); rst_n = 1'b1;

    // Basic read: SETUP cycle 1, ACCESS cycle 2, ack cycle 3
    addr0_in = 32'h8c00_0010; prdata_in = 32'hA5A5_0001; req_in = 2'b01;
    step();
    chk("t1_setup_psel", {31'b0, psel_out}, 32'h1);
    chk("t1_setup_pen",  {31'b0, penable_out}, 32'h0);
    chk("t1_setup_paddr", paddr_out, 32'h8c00_0010);
    step();
    chk("t1_access_pen", {31'b0, penable_out}, 32'h1);
    chk("t1_access_psel", {31'b0, psel_out}, 32'h1);
    step();
    chk("t1_ack", {30'b0, ack_out}, 32'h1);
    chk("t1_rdata", rdata_out, 32'hA5A5_0001);
    chk("t1_err", {31'b0, err_out}, 32'h0);
    chk("t1_done_psel", {31'b0, psel_out}, 32'h0);
    req_in = 2'b00;
    step();
    chk("t1_ack_drop", {30'b0, ack_out}, 32'h0);

    // Round robin with both requesting; fresh reset so requester 0 wins first
    rst_n = 1'b0; step(); rst_n = 1'b1;
    addr0_in = 32'h8c00_0100; addr1_in = 32'h8c00_0200; prdata_in = 32'h11;
    req_in = 2'b11;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rr_paddr", paddr_out, k[0] ? 32'h8c00_0200 : 32'h8c00_0100);
      step();
      step();
      chk("rr_ack", {30'b0, ack_out}, k[0] ? 32'h2 : 32'h1);
      chk("rr_done_psel", {31'b0, psel_out}, 32'h0);
      step();
      chk("rr_ack_once", {30'b0, ack_out}, 32'h0);
      chk("rr_idle_psel", {31'b0, psel_out}, 32'h0);
      if (k == 2) req_in = 2'b00;
    end

    // Top legal word: full bus access
    addr0_in = 32'h8c00_07FC; write_in = 2'b01; wdata0_in = 32'h0000_BEEF; req_in = 2'b01;
    step();
    chk("end_psel", {31'b0, psel_out}, 32'h1);
    chk("end_paddr", paddr_out, 32'h8c00_07FC);
    step(); step();
    chk("end_ack", {30'b0, ack_out}, 32'h1);
    chk("end_err", {31'b0, err_out}, 32'h0);
    chk("end_wr_rdata", rdata_out, 32'h0);
    req_in = 2'b00; write_in = 2'b00;
    step();

    // Just past the window: immediate error ack, no bus
    addr0_in = 32'h8c00_0800; req_in = 2'b01;
    step();
    chk("oob_ack", {30'b0, ack_out}, 32'h1);
    chk("oob_err", {31'b0, err_out}, 32'h1);
    chk("oob_psel", {31'b0, psel_out}, 32'h0);
    req_in = 2'b00;
    step();
    chk("oob_psel2", {31'b0, psel_out}, 32'h0);

    // Misaligned
    addr0_in = 32'h8c00_0002; req_in = 2'b01;
    step();
    chk("mis_ack", {30'b0, ack_out}, 32'h1);
    chk("mis_err", {31'b0, err_out}, 32'h1);
    chk("mis_psel", {31'b0, psel_out}, 32'h0);
    req_in = 2'b00;
    step();

    // Top of the 32-bit map on requester 1: no wrap
    addr1_in = 32'hFFFF_FFFC; req_in = 2'b10;
    step();
    chk("top_ack", {30'b0, ack_out}, 32'h2);
    chk("top_err", {31'b0, err_out}, 32'h1);
    chk("top_psel", {31'b0, psel_out}, 32'h0);
    req_in = 2'b00;
    step();

    // Write with slave error
    addr0_in = 32'h8c00_0020; wdata0_in = 32'hDEAD_BEEF; write_in = 2'b01;
    pslverr_in = 1'b1; req_in = 2'b01;
    step();
    chk("wr_setup_pwdata", pwdata_out, 32'hDEAD_BEEF);
    chk("wr_pwrite", {31'b0, pwrite_out}, 32'h1);
    step();
    chk("wr_access_pwdata", pwdata_out, 32'hDEAD_BEEF);
    chk("wr_access_pen", {31'b0, penable_out}, 32'h1);
    step();
    chk("wr_ack", {30'b0, ack_out}, 32'h1);
    chk("wr_err", {31'b0, err_out}, 32'h1);
    chk("wr_rdata", rdata_out, 32'h0);
    req_in = 2'b00; write_in = 2'b00; pslverr_in = 1'b0;
    step();
    chk("wr_pwdata_hold", pwdata_out, 32'hDEAD_BEEF);

    // Wait states
    addr0_in = 32'h8c00_0030; prdata_in = 32'h0000_005A; pready_in = 1'b0; req_in = 2'b01;
    step(); step();
    chk("ws_access_pen", {31'b0, penable_out}, 32'h1);
`ifdef APB_ARB_TIMEOUT_EN
    step();
    chk("to_ack", {30'b0, ack_out}, 32'h1);
    chk("to_err", {31'b0, err_out}, 32'h1);
    chk("to_rdata", rdata_out, 32'h0);
    chk("to_psel", {31'b0, psel_out}, 32'h0);
`else
    for (int i = 0; i < 4; i++) begin
      step();
      chk("ws_hold_pen", {31'b0, penable_out}, 32'h1);
      chk("ws_no_ack", {30'b0, ack_out}, 32'h0);
    end
    pready_in = 1'b1;
    step();
    chk("ws_ack", {30'b0, ack_out}, 32'h1);
    chk("ws_err", {31'b0, err_out}, 32'h0);
    chk("ws_rdata", rdata_out, 32'h0000_005A);
`endif
    req_in = 2'b00; pready_in = 1'b1;
    step();

    // Reset during ACCESS, then lone requester 1
    addr0_in = 32'h8c00_0034; pready_in = 1'b0; req_in = 2'b01;
    step(); step();
    chk("mr_access_pen", {31'b0, penable_out}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_psel", {31'b0, psel_out}, 32'h0);
    chk("mr_pen", {31'b0, penable_out}, 32'h0);
    chk("mr_ack", {30'b0, ack_out}, 32'h0);
    req_in = 2'b10; addr1_in = 32'h8c00_0040; pready_in = 1'b1; prdata_in = 32'h1234_5678;
    step(); rst_n = 1'b1;
    step();
    chk("mr_g1_paddr", paddr_out, 32'h8c00_0040);
    chk("mr_g1_psel", {31'b0, psel_out}, 32'h1);
    step(); step();
    chk("mr_g1_ack", {30'b0, ack_out}, 32'h2);
    chk("mr_g1_rdata", rdata_out, 32'h1234_5678);
    req_in = 2'b00;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

endmodule
